// File: rtl/crc_pkg.sv
// Shared types and constants for the CRC frame checker and generator.
// Registers are MSB-justified; only the top WIDTH bits are significant.
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK
    } state_e;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

    function automatic logic [31:0] width_mask(
        input int unsigned w
    );
        logic [31:0] m;
        m = '1;
        return m << (32 - w);
    endfunction

    function automatic logic [7:0] bitrev8(
        input logic [7:0] b
    );
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc_step.sv
// One bit-serial LFSR step over an MSB-justified CRC register.
// Shared with the CRC generator.
module crc_step (
    input  logic [31:0] crc_i,
    input  logic        bit_i,
    input  logic [31:0] poly_i,
    output logic [31:0] crc_o
);

    logic fb;

    assign fb    = crc_i[31] ^ bit_i;
    assign crc_o = {crc_i[30:0], 1'b0} ^ (fb ? poly_i : 32'h0);

endmodule

// File: rtl/crc_frame_checker.sv
// Streaming CRC frame checker: shifts every byte, CRC bytes included,
// through the LFSR and compares the final register to the residue.
module crc_frame_checker
    import crc_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter logic [31:0] POLY    = CRC32_POLY,
    parameter logic [31:0] INIT    = CRC32_INIT,
    parameter logic [31:0] RESIDUE = CRC32_RESIDUE,
    parameter bit          REFIN   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        res_valid,
    output logic        res_ok,
    output logic        res_runt,
    output logic [15:0] res_len,
    output logic [15:0] cnt_ok,
    output logic [15:0] cnt_bad,
    output logic [31:0] crc_out
);

    localparam logic [31:0] MASK    = width_mask(WIDTH);
    localparam logic [15:0] MIN_LEN = 16'(WIDTH / 8 + 1);

    state_e      state_q;
    logic [31:0] crc_q;
    logic [31:0] crc_d;
    logic [7:0]  sh_q;
    logic [7:0]  sh_d;
    logic        last_q;
    logic [2:0]  bit_cnt_q;
    logic [15:0] len_q;
    logic [15:0] len_d;
    logic [15:0] cnt_ok_q;
    logic [15:0] cnt_ok_d;
    logic [15:0] cnt_bad_q;
    logic [15:0] cnt_bad_d;
    logic        res_valid_q;
    logic        res_ok_q;
    logic        res_runt_q;
    logic [15:0] res_len_q;
    logic        accept;
    logic        runt;
    logic        match;
    logic        good;

    crc_step u_step (
        .crc_i  (crc_q),
        .bit_i  (sh_q[7]),
        .poly_i (POLY),
        .crc_o  (crc_d)
    );

    // Holding off ready during clr keeps a byte from being silently dropped.
    assign in_ready = (state_q == IDLE) & ~rst & ~clr;
    assign accept   = in_valid & in_ready;

    assign sh_d = REFIN ? bitrev8(in_data) : in_data;

    assign len_d     = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
    assign cnt_ok_d  = (cnt_ok_q == 16'hFFFF) ? cnt_ok_q
                                              : cnt_ok_q + 16'd1;
    assign cnt_bad_d = (cnt_bad_q == 16'hFFFF) ? cnt_bad_q
                                               : cnt_bad_q + 16'd1;

    assign runt  = len_q < MIN_LEN;
    assign match = ((crc_q ^ RESIDUE) & MASK) == 32'h0;
    assign good  = ~runt & match;

    always_ff @(posedge clk) begin
        res_valid_q <= 1'b0;
        if (rst) begin
            state_q    <= IDLE;
            crc_q      <= INIT;
            sh_q       <= 8'h00;
            last_q     <= 1'b0;
            bit_cnt_q  <= 3'd0;
            len_q      <= 16'h0;
            cnt_ok_q   <= 16'h0;
            cnt_bad_q  <= 16'h0;
            res_ok_q   <= 1'b0;
            res_runt_q <= 1'b0;
            res_len_q  <= 16'h0;
        end else if (clr) begin
            state_q   <= IDLE;
            crc_q     <= INIT;
            len_q     <= 16'h0;
            cnt_ok_q  <= 16'h0;
            cnt_bad_q <= 16'h0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        sh_q      <= sh_d;
                        last_q    <= in_last;
                        len_q     <= len_d;
                        bit_cnt_q <= 3'd7;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    crc_q <= crc_d;
                    sh_q  <= {sh_q[6:0], 1'b0};
                    if (bit_cnt_q == 3'd0) begin
                        state_q <= last_q ? CHECK : IDLE;
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 3'd1;
                    end
                end
                CHECK: begin
                    res_valid_q <= 1'b1;
                    res_ok_q    <= good;
                    res_runt_q  <= runt;
                    res_len_q   <= len_q;
                    if (good) begin
                        cnt_ok_q <= cnt_ok_d;
                    end else begin
                        cnt_bad_q <= cnt_bad_d;
                    end
                    crc_q   <= INIT;
                    len_q   <= 16'h0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign res_valid = res_valid_q;
    assign res_ok    = res_ok_q;
    assign res_runt  = res_runt_q;
    assign res_len   = res_len_q;
    assign cnt_ok    = cnt_ok_q;
    assign cnt_bad   = cnt_bad_q;
    assign crc_out   = crc_q & MASK;

endmodule

// File: tb/tb_crc_frame_checker.sv
// Directed bench for crc_frame_checker: CRC-32 check frame, bit error,
// runt, streaming timing, reset abort, saturation and clear.
module tb_crc_frame_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;
    logic        res_valid;
    logic        res_ok;
    logic        res_runt;
    logic [15:0] res_len;
    logic [15:0] cnt_ok;
    logic [15:0] cnt_bad;
    logic [31:0] crc_out;

    crc_frame_checker dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .res_valid (res_valid),
        .res_ok    (res_ok),
        .res_runt  (res_runt),
        .res_len   (res_len),
        .cnt_ok    (cnt_ok),
        .cnt_bad   (cnt_bad),
        .crc_out   (crc_out)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    // Result log captured on every res_valid pulse.
    int          nres = 0;
    logic [31:0] lg_ok   [8];
    logic [31:0] lg_runt [8];
    logic [31:0] lg_len  [8];
    logic [31:0] lg_cok  [8];
    logic [31:0] lg_cbad [8];
    int unsigned lg_cyc  [8];

    always @(negedge clk) begin
        if (res_valid === 1'b1) begin
            if (nres < 8) begin
                lg_ok[nres]   = {31'b0, res_ok};
                lg_runt[nres] = {31'b0, res_runt};
                lg_len[nres]  = {16'b0, res_len};
                lg_cok[nres]  = {16'b0, cnt_ok};
                lg_cbad[nres] = {16'b0, cnt_bad};
                lg_cyc[nres]  = cyc;
            end
            nres++;
        end
    end

    logic [7:0] cur [13] = '{
        8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
        8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB
    };

    int unsigned acc [64];
    int          nacc = 0;

    // Entered on a negedge; returns on the negedge after the accept.
    task automatic send_byte(
        input  logic [7:0] d,
        input  logic       l,
        output bit         ok
    );
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                acc[nacc % 64] = cyc;
                nacc++;
            end
            @(negedge clk);
        end
    endtask

    task automatic send_frame(
        input int    s,
        input int    n,
        input string tag
    );
        bit ok;
        bit all;
        all = 1'b1;
        for (int i = 0; i < n; i++) begin
            send_byte(cur[s+i], i == n - 1, ok);
            all &= ok;
        end
        chk({tag, "_hs"}, {31'b0, all}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n0;
        int n1;
        int unsigned last_acc [3];
        logic [31:0] e_ok   [3] = '{1, 0, 0};
        logic [31:0] e_runt [3] = '{0, 0, 1};
        logic [31:0] e_len  [3] = '{13, 13, 4};
        logic [31:0] e_cbad [3] = '{0, 1, 2};

        rst      = 1'b1;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_valid", {31'b0, res_valid}, 32'd0);
        chk("rst_ok", {31'b0, res_ok}, 32'd0);
        chk("rst_runt", {31'b0, res_runt}, 32'd0);
        chk("rst_len", {16'b0, res_len}, 32'd0);
        chk("rst_cok", {16'b0, cnt_ok}, 32'd0);
        chk("rst_cbad", {16'b0, cnt_bad}, 32'd0);
        chk("rst_crc", crc_out, 32'hFFFFFFFF);
        rst = 1'b0;
        #1;
        chk("ready_post_rst", {31'b0, in_ready}, 32'd1);
        @(negedge clk);

        // Good, bit-flipped and runt frames streamed back to back.
        nacc = 0;
        send_frame(0, 13, "good");
        last_acc[0] = acc[12];
        cur[0] = 8'h30;
        send_frame(0, 13, "flip");
        last_acc[1] = acc[25];
        cur[0] = 8'h31;
        send_frame(9, 4, "runt");
        last_acc[2] = acc[29];
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (15) @(negedge clk);

        chk("stream_nres", nres, 32'd3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("ok%0d", k), lg_ok[k], e_ok[k]);
            chk($sformatf("runt%0d", k), lg_runt[k], e_runt[k]);
            chk($sformatf("len%0d", k), lg_len[k], e_len[k]);
            chk($sformatf("cok%0d", k), lg_cok[k], 32'd1);
            chk($sformatf("cbad%0d", k), lg_cbad[k], e_cbad[k]);
            chk($sformatf("lat%0d", k),
                lg_cyc[k] - last_acc[k], 32'd10);
        end
        for (int i = 0; i < 29; i++) begin
            chk($sformatf("gap%0d", i), acc[i+1] - acc[i],
                (i == 12 || i == 25) ? 32'd10 : 32'd9);
        end
        chk("crc_after", crc_out, 32'hFFFFFFFF);
        chk("ready_idle", {31'b0, in_ready}, 32'd1);

        // Reset in the 4th SHIFT cycle of byte 6, then replay.
        n0 = nres;
        for (int i = 0; i < 6; i++) begin
            send_byte(cur[i], 1'b0, ok);
        end
        repeat (3) @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("abort_cok", {16'b0, cnt_ok}, 32'd0);
        chk("abort_cbad", {16'b0, cnt_bad}, 32'd0);
        chk("abort_len", {16'b0, res_len}, 32'd0);
        chk("abort_crc", crc_out, 32'hFFFFFFFF);
        repeat (12) @(negedge clk);
        chk("abort_nres", nres, n0);
        send_frame(0, 13, "replay");
        in_valid = 1'b0;
        repeat (12) @(negedge clk);
        chk("replay_nres", nres, n0 + 1);
        chk("replay_ok", lg_ok[n0], 32'd1);
        chk("replay_len", lg_len[n0], 32'd13);
        chk("replay_cok", lg_cok[n0], 32'd1);

        // Saturation of the good-frame counter.
        force dut.cnt_ok_q = 16'hFFFE;
        @(negedge clk);
        release dut.cnt_ok_q;
        @(negedge clk);
        send_frame(0, 13, "sat1");
        send_frame(0, 13, "sat2");
        in_valid = 1'b0;
        repeat (12) @(negedge clk);
        chk("sat_nres", nres, n0 + 3);
        chk("sat_cok1", lg_cok[n0+1], 32'h0000FFFF);
        chk("sat_cok2", lg_cok[n0+2], 32'h0000FFFF);
        chk("sat_cok", {16'b0, cnt_ok}, 32'h0000FFFF);

        // clr in the CHECK cycle beats the counter update.
        n1 = nres;
        for (int i = 0; i < 13; i++) begin
            send_byte(cur[i], i == 12, ok);
        end
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_valid", {31'b0, res_valid}, 32'd0);
        chk("clr_cok", {16'b0, cnt_ok}, 32'd0);
        chk("clr_cbad", {16'b0, cnt_bad}, 32'd0);
        chk("clr_crc", crc_out, 32'hFFFFFFFF);
        repeat (3) @(negedge clk);
        chk("clr_nres", nres, n1);
        chk("clr_ready", {31'b0, in_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
